// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: shares the 16x16 red/green LED driver between two frame producers.
// Latency: Gnt, FrameStart and the new front-buffer pixels appear together, one cycle after a frame's last strobe.
// Backpressure: a producer holds Req with stable pixels until its Gnt pulse; dropping Req early withdraws it.
// Optional feature: define LED_SCHED_RR_EN for round-robin tie-breaking (default: fixed priority Req0 > Req1).
module led_frame_scheduler #(
  parameter int FREQDIV = 15
) (
  input  logic              Clock,
  input  logic              RST_n,
  input  logic [9:0]        Speed,
  input  logic              Req0,
  input  logic [15:0][15:0] Red0,
  input  logic [15:0][15:0] Grn0,
  input  logic              Req1,
  input  logic [15:0][15:0] Red1,
  input  logic [15:0][15:0] Grn1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              FrameStart,
  output logic              Owner,
  output logic              Valid,
  output logic              slowdownCount,
  output logic [15:0][15:0] RedPixels,
  output logic [15:0][15:0] GrnPixels
);

  // The driver counts 2^FREQDIV strobes per row and 16 rows per frame.
  localparam int SCAN_W = FREQDIV + 4;

  typedef enum logic {
    EMPTY   = 1'b0,
    SHOWING = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [9:0]        div_q, div_d;
  logic              strobe_q, strobe_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              fstart_q, fstart_d;
  logic              owner_q, owner_d;
  logic              last_gnt_q, last_gnt_d;
  logic [15:0][15:0] red_q, red_d;
  logic [15:0][15:0] grn_q, grn_d;

  logic boundary;
  logic any_req;
  logic winner;
  logic commit;

  // Row-advance divider: one strobe every Speed+1 cycles; the >= compare makes a lowered Speed fire at once.
  always_comb begin
    div_d    = div_q + 10'd1;
    strobe_d = 1'b0;
    if (div_q >= Speed) begin
      div_d    = '0;
      strobe_d = 1'b1;
    end
  end

  // Scan mirror steps on the same strobe edge the driver counts, so both stay in lockstep.
  always_comb begin
    scan_d = scan_q;
    if (strobe_q) begin
      scan_d = scan_q + SCAN_W'(1);
    end
  end

  // The frame ends on the strobe that wraps the scan position back to row 0.
  assign boundary = strobe_q && (scan_q == {SCAN_W{1'b1}});
  assign any_req  = Req0 | Req1;
  assign commit   = boundary & any_req;

`ifdef LED_SCHED_RR_EN
  // Round-robin: on a tie the producer not granted last time wins; a lone requester always wins.
  always_comb begin
    winner = ~Req0;
    if (Req0 && Req1) begin
      winner = ~last_gnt_q;
    end
  end
`else
  // Fixed priority: producer 0 always wins; producer 1 only when producer 0 is idle.
  always_comb begin
    winner = ~Req0;
  end
`endif

  // Frame commit and display FSM: the front buffer only ever changes on a granted boundary.
  always_comb begin
    state_d    = state_q;
    fstart_d   = boundary;
    gnt0_d     = commit & ~winner;
    gnt1_d     = commit & winner;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    red_d      = red_q;
    grn_d      = grn_q;
    if (commit) begin
      owner_d    = winner;
      last_gnt_d = winner;
      red_d      = winner ? Red1 : Red0;
      grn_d      = winner ? Grn1 : Grn0;
    end
    case (state_q)
      EMPTY:   if (commit) state_d = SHOWING;
      SHOWING: state_d = SHOWING;
    endcase
  end

  // State registers with synchronous active-low reset; reset mid-frame restarts the scan from row 0.
  always_ff @(posedge Clock) begin
    if (!RST_n) begin
      state_q    <= EMPTY;
      div_q      <= '0;
      strobe_q   <= 1'b0;
      scan_q     <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      fstart_q   <= 1'b0;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      red_q      <= '0;
      grn_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      strobe_q   <= strobe_d;
      scan_q     <= scan_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      fstart_q   <= fstart_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      red_q      <= red_d;
      grn_q      <= grn_d;
    end
  end

  assign slowdownCount = strobe_q;
  assign FrameStart    = fstart_q;
  assign Gnt0          = gnt0_q;
  assign Gnt1          = gnt1_q;
  assign Owner         = owner_q;
  assign Valid         = (state_q == SHOWING);
  assign RedPixels     = red_q;
  assign GrnPixels     = grn_q;

endmodule
